hazard_control_unit: RTL and testbench

- Stall/flush controller for the 5-stage MIPS pipeline.
- Produces enable and flush strobes for the PC and the four pipeline latches, covering:
  - load-use hazards that forwarding cannot resolve;
  - icache and dcache wait cycles;
  - taken branch/jump squash;
  - halt.
- It works alongside the forwarding unit. It inserts exactly the bubbles that forwarding needs, and its register-0 and rd/rt matching rules are the same as the forwarding unit's.

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/hazard_control_unit_if.sv | 29 ++
 rtl/sat_counter.sv | 16 +
 rtl/hazard_control_unit.sv | 137 +++++++++++++
 tb/tb_hazard_control_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register index type and hazard controller states.
package cpu_types_pkg;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    SQUASH = 2'd2,
    HALTED = 2'd3
  } hazard_state_t;
endpackage

// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
interface hazard_control_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             ihit, dhit;
  logic [REG_W-1:0] ifid_rs, ifid_rt, idex_rt;
  logic             idex_dren, exmem_dren, exmem_dwen, exmem_pcsrc, exmem_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt, loaduse_cnt, squash_cnt;

  modport hcu (
    input  ihit, dhit, ifid_rs, ifid_rt, idex_rt, idex_dren,
           exmem_dren, exmem_dwen, exmem_pcsrc, exmem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cnt, loaduse_cnt, squash_cnt
  );

  modport datapath (
    output ihit, dhit, ifid_rs, ifid_rt, idex_rt, idex_dren,
           exmem_dren, exmem_dwen, exmem_pcsrc, exmem_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cnt, loaduse_cnt, squash_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      count <= '0;
    else if (en && (count != '1))
      count <= count + W'(1);
  end
endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline (load-use, cache waits, squash, halt).
// Define HAZARD_STATS_EN to build the stall/load-use/squash statistics counters.
module hazard_control_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_dren,
  input  logic             exmem_dren,
  input  logic             exmem_dwen,
  input  logic             exmem_pcsrc,
  input  logic             exmem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] squash_cnt
);
  import cpu_types_pkg::*;

  hazard_state_t state_reg, state_next, mode;
  logic          ret_squash_reg, ret_squash_next;
  logic          allow_miss, miss, load_use;
  logic [4:0]    en;   // {pc, ifid, idex, exmem, memwb}
  logic [3:0]    fl;   // {ifid, idex, exmem, memwb}

  assign miss     = (exmem_dren | exmem_dwen) & ~dhit;
  assign load_use = idex_dren & (idex_rt != '0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= RUN;
      ret_squash_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ret_squash_reg <= ret_squash_next;
    end
  end

  always_comb begin
    en              = 5'b11111;
    fl              = 4'b0000;
    state_next      = state_reg;
    ret_squash_next = ret_squash_reg;
    allow_miss      = 1'b1;
    mode            = state_reg;
    // On the dhit cycle the waiting state re-evaluates as its origin state, minus the miss rule.
    if (state_reg == DWAIT && dhit) begin
      mode       = ret_squash_reg ? SQUASH : RUN;
      allow_miss = 1'b0;
    end

    case (mode)
      RUN: begin
        state_next = RUN;
        if (exmem_halt) begin
          en = 5'b00000; fl = 4'b0001; state_next = HALTED;
        end else if (allow_miss && miss) begin
          en = 5'b00001; fl = 4'b0001; state_next = DWAIT; ret_squash_next = 1'b0;
        end else if (exmem_pcsrc) begin
          fl = 4'b1110; state_next = ihit ? RUN : SQUASH;
        end else if (load_use) begin
          en = 5'b00111; fl = 4'b0100;
        end else if (!ihit) begin
          en = 5'b01111; fl = 4'b1000;
        end
      end
      SQUASH: begin
        state_next = SQUASH;
        en = 5'b01111; fl = 4'b1000;
        if (exmem_halt) begin
          en = 5'b00000; fl = 4'b0001; state_next = HALTED;
        end else if (allow_miss && miss) begin
          en = 5'b00001; fl = 4'b0001; state_next = DWAIT; ret_squash_next = 1'b1;
        end else if (exmem_pcsrc) begin
          en = 5'b11111; fl = 4'b1110;
        end else if (ihit) begin
          en = 5'b11111; fl = 4'b1000; state_next = RUN;
        end
      end
      DWAIT: begin
        en = 5'b00001; fl = 4'b0001; state_next = DWAIT;
      end
      default: begin
        en = 5'b00000; fl = 4'b0000; state_next = HALTED;
      end
    endcase

    if (RST) begin
      en = 5'b00000;
      fl = 4'b1111;
    end
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en;
  assign {ifid_flush, idex_flush, exmem_flush, memwb_flush} = fl;
  assign halted = (state_reg == HALTED) & ~RST;

`ifdef HAZARD_STATS_EN
  logic stall_evt, lu_evt, sq_evt;

  assign stall_evt = ~en[4] & (state_reg != HALTED) & ~RST;
  // Output signatures: only load-use holds IF/ID while bubbling ID/EX without flushing IF/ID,
  // and only a branch squash flushes EX/MEM with the PC advancing.
  assign lu_evt = ~en[3] & fl[2] & ~fl[3];
  assign sq_evt = en[4] & fl[1];

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(CLK), .clr(RST), .en(stall_evt), .count(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_loaduse_cnt (
    .clk(CLK), .clr(RST), .en(lu_evt), .count(loaduse_cnt)
  );
  sat_counter #(.W(CNT_W)) u_squash_cnt (
    .clk(CLK), .clr(RST), .en(sq_evt), .count(squash_cnt)
  );
`else
  assign stall_cnt   = '0;
  assign loaduse_cnt = '0;
  assign squash_cnt  = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit.
module tb_hazard_control_unit;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   exp_stall = 0, exp_lu = 0, exp_sq = 0;

  hazard_control_unit_if #(.REG_W(5), .CNT_W(16)) hif ();

  hazard_control_unit #(.REG_W(5), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .ihit(hif.ihit), .dhit(hif.dhit),
    .ifid_rs(hif.ifid_rs), .ifid_rt(hif.ifid_rt), .idex_rt(hif.idex_rt),
    .idex_dren(hif.idex_dren), .exmem_dren(hif.exmem_dren),
    .exmem_dwen(hif.exmem_dwen), .exmem_pcsrc(hif.exmem_pcsrc),
    .exmem_halt(hif.exmem_halt),
    .pc_en(hif.pc_en), .ifid_en(hif.ifid_en), .idex_en(hif.idex_en),
    .exmem_en(hif.exmem_en), .memwb_en(hif.memwb_en),
    .ifid_flush(hif.ifid_flush), .idex_flush(hif.idex_flush),
    .exmem_flush(hif.exmem_flush), .memwb_flush(hif.memwb_flush),
    .halted(hif.halted),
    .stall_cnt(hif.stall_cnt), .loaduse_cnt(hif.loaduse_cnt), .squash_cnt(hif.squash_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // en = {pc, ifid, idex, exmem, memwb}, fl = {ifid, idex, exmem, memwb}
  task automatic outs(input string tag, input logic [4:0] en, input logic [3:0] fl, input logic h);
    chk({tag, ".en"}, 16'({hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en}), 16'(en));
    chk({tag, ".fl"}, 16'({hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush}), 16'(fl));
    chk({tag, ".halted"}, 16'(hif.halted), 16'(h));
    $display("step %s: en=%b fl=%b halted=%b", tag,
             {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en},
             {hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush}, hif.halted);
  endtask

  task automatic cnts(input string tag);
    chk({tag, ".stall_cnt"},   hif.stall_cnt,   STATS ? 16'(exp_stall) : 16'd0);
    chk({tag, ".loaduse_cnt"}, hif.loaduse_cnt, STATS ? 16'(exp_lu)    : 16'd0);
    chk({tag, ".squash_cnt"},  hif.squash_cnt,  STATS ? 16'(exp_sq)    : 16'd0);
  endtask

  task automatic idle();
    hif.ihit = 1'b1; hif.dhit = 1'b1;
    hif.ifid_rs = '0; hif.ifid_rt = '0; hif.idex_rt = '0;
    hif.idex_dren = 1'b0; hif.exmem_dren = 1'b0; hif.exmem_dwen = 1'b0;
    hif.exmem_pcsrc = 1'b0; hif.exmem_halt = 1'b0;
  endtask

  initial begin
    idle();
    #1;
    outs("reset", 5'b00000, 4'b1111, 1'b0);
    cnts("reset");
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0; #1;
    outs("run_idle", 5'b11111, 4'b0000, 1'b0);

    // load-use on rs
    @(negedge CLK); idle(); hif.idex_dren = 1; hif.idex_rt = 5'd5; hif.ifid_rs = 5'd5; #1;
    outs("lu_rs", 5'b00111, 4'b0100, 1'b0); exp_stall++; exp_lu++;
    @(negedge CLK); idle(); #1;
    outs("lu_after", 5'b11111, 4'b0000, 1'b0);
    cnts("lu_after");
    // register 0 never stalls
    @(negedge CLK); idle(); hif.idex_dren = 1; #1;
    outs("lu_r0", 5'b11111, 4'b0000, 1'b0);
    // load-use on rt
    @(negedge CLK); idle(); hif.idex_dren = 1; hif.idex_rt = 5'd7; hif.ifid_rt = 5'd7; hif.ifid_rs = 5'd3; #1;
    outs("lu_rt", 5'b00111, 4'b0100, 1'b0); exp_stall++; exp_lu++;
    // icache miss alone
    @(negedge CLK); idle(); hif.ihit = 0; #1;
    outs("imiss", 5'b01111, 4'b1000, 1'b0); exp_stall++;
    // load-use beats icache miss
    @(negedge CLK); idle(); hif.ihit = 0; hif.idex_dren = 1; hif.idex_rt = 5'd5; hif.ifid_rs = 5'd5; #1;
    outs("lu_imiss", 5'b00111, 4'b0100, 1'b0); exp_stall++; exp_lu++;
    @(negedge CLK); idle(); #1;
    cnts("after_lu");

    // dcache miss for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); idle(); hif.exmem_dren = 1; hif.dhit = 0; #1;
      outs($sformatf("dmiss%0d", i), 5'b00001, 4'b0001, 1'b0); exp_stall++;
    end
    @(negedge CLK); idle(); hif.exmem_dren = 1; #1;
    outs("dhit", 5'b11111, 4'b0000, 1'b0);
    @(negedge CLK); idle(); #1;
    cnts("after_dmiss");

    // taken branch with pending fetch
    @(negedge CLK); idle(); hif.exmem_pcsrc = 1; hif.ihit = 0; #1;
    outs("br_squash", 5'b11111, 4'b1110, 1'b0); exp_sq++;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); idle(); hif.ihit = 0; #1;
      outs($sformatf("sq_wait%0d", i), 5'b01111, 4'b1000, 1'b0); exp_stall++;
    end
    @(negedge CLK); idle(); #1;
    outs("sq_ihit", 5'b11111, 4'b1000, 1'b0);
    @(negedge CLK); idle(); #1;
    outs("sq_back_run", 5'b11111, 4'b0000, 1'b0);
    cnts("after_branch");

    // dcache miss wins over pcsrc; squash happens on dhit
    @(negedge CLK); idle(); hif.exmem_dwen = 1; hif.dhit = 0; hif.exmem_pcsrc = 1; #1;
    outs("prio_freeze", 5'b00001, 4'b0001, 1'b0); exp_stall++;
    @(negedge CLK); idle(); hif.exmem_dwen = 1; hif.exmem_pcsrc = 1; #1;
    outs("prio_dhit", 5'b11111, 4'b1110, 1'b0); exp_sq++;
    @(negedge CLK); idle(); #1;
    outs("prio_run", 5'b11111, 4'b0000, 1'b0);

    // dcache miss during SQUASH returns to SQUASH
    @(negedge CLK); idle(); hif.exmem_pcsrc = 1; hif.ihit = 0; #1;
    outs("sqm_br", 5'b11111, 4'b1110, 1'b0); exp_sq++;
    @(negedge CLK); idle(); hif.ihit = 0; hif.exmem_dren = 1; hif.dhit = 0; #1;
    outs("sqm_freeze", 5'b00001, 4'b0001, 1'b0); exp_stall++;
    @(negedge CLK); idle(); hif.ihit = 0; hif.exmem_dren = 1; #1;
    outs("sqm_dhit", 5'b01111, 4'b1000, 1'b0); exp_stall++;
    @(negedge CLK); idle(); #1;
    outs("sqm_ihit", 5'b11111, 4'b1000, 1'b0);
    @(negedge CLK); idle(); #1;
    outs("sqm_run", 5'b11111, 4'b0000, 1'b0);

    // new pcsrc while in SQUASH keeps SQUASH even with ihit
    @(negedge CLK); idle(); hif.exmem_pcsrc = 1; hif.ihit = 0; #1;
    outs("sq2_br", 5'b11111, 4'b1110, 1'b0); exp_sq++;
    @(negedge CLK); idle(); hif.exmem_pcsrc = 1; #1;
    outs("sq2_br_again", 5'b11111, 4'b1110, 1'b0); exp_sq++;
    @(negedge CLK); idle(); #1;
    outs("sq2_ihit", 5'b11111, 4'b1000, 1'b0);
    @(negedge CLK); idle(); #1;
    outs("sq2_run", 5'b11111, 4'b0000, 1'b0);
    cnts("after_squash");

    // asynchronous reset in the middle of DWAIT
    @(negedge CLK); idle(); hif.exmem_dren = 1; hif.dhit = 0; #1;
    outs("rst_dmiss", 5'b00001, 4'b0001, 1'b0);
    @(negedge CLK); #1;
    outs("rst_dwait", 5'b00001, 4'b0001, 1'b0);
    #2 RST = 1'b1; #1;
    exp_stall = 0; exp_lu = 0; exp_sq = 0;
    outs("rst_async", 5'b00000, 4'b1111, 1'b0);
    cnts("rst_async");
    @(negedge CLK); RST = 1'b0; idle(); #1;
    outs("rst_release", 5'b11111, 4'b0000, 1'b0);

    // halt is sticky until reset
    @(negedge CLK); idle(); hif.exmem_halt = 1; #1;
    outs("halt_req", 5'b00000, 4'b0001, 1'b0); exp_stall++;
    @(negedge CLK); idle(); hif.exmem_pcsrc = 1; hif.ihit = 0; hif.exmem_dren = 1; hif.dhit = 0; #1;
    outs("halted_busy", 5'b00000, 4'b0000, 1'b1);
    @(negedge CLK); idle(); hif.idex_dren = 1; hif.idex_rt = 5'd4; hif.ifid_rs = 5'd4; #1;
    outs("halted_lu", 5'b00000, 4'b0000, 1'b1);
    @(negedge CLK); idle(); #1;
    outs("halted_idle", 5'b00000, 4'b0000, 1'b1);
    cnts("halted");
    RST = 1'b1; #1;
    outs("halt_rst", 5'b00000, 4'b1111, 1'b0);
    @(negedge CLK); RST = 1'b0; #1;
    outs("halt_exit", 5'b11111, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
